// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_ctrl
//  Brief    : Read-side controller of the async FIFO: read pointer, empty
//             flags and a 2-entry output buffer over a registered-read memory.
//  Revision : 1.0
// ============================================================================
module fifo_rd_ctrl #(
    parameter int DATASIZE         = 8,
    parameter int ADDRSIZE         = 4,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr_gray,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic                mem_rinc,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rempty,
    output logic                raempty
);

    localparam int                 c_PW     = ADDRSIZE + 1;
    localparam logic [c_PW-1:0]    c_AE_LVL = c_PW'(ALMOST_EMPTY_LVL);

    function automatic logic [c_PW-1:0] gray2bin(input logic [c_PW-1:0] g);
        logic [c_PW-1:0] b;
        b[c_PW-1] = g[c_PW-1];
        for (int i = c_PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [c_PW-1:0] bin2gray(input logic [c_PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [c_PW-1:0]     r_wq1;
    logic [c_PW-1:0]     r_wq2;
    logic [c_PW-1:0]     r_rbin;
    logic [c_PW-1:0]     r_rptr_gray;
    logic                r_inflight;
    logic [DATASIZE-1:0] r_buf_head;
    logic [DATASIZE-1:0] r_buf_tail;
    logic [1:0]          r_bufcnt;

    logic [c_PW-1:0]     w_wbin;
    logic [c_PW-1:0]     w_memcnt;
    logic [c_PW-1:0]     w_rbin_next;
    logic [2:0]          w_occ_after_pop;
    logic                w_pop;
    logic                w_issue;

    // Two-flop synchroniser for the write pointer
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= wptr_gray;
            r_wq2 <= r_wq1;
        end
    end

    assign w_wbin      = gray2bin(r_wq2);
    assign w_memcnt    = w_wbin - r_rbin;
    assign w_pop       = m_valid & m_ready;
    assign w_rbin_next = r_rbin + c_PW'(1);

    // Buffered plus in-flight words that remain after this cycle's pop must
    // leave room for the word about to be requested.
    assign w_occ_after_pop = {1'b0, r_bufcnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue         = (w_memcnt != '0) && (w_occ_after_pop < 3'd2);

    assign mem_rinc  = w_issue;
    assign mem_addr  = r_rbin[ADDRSIZE-1:0];
    assign rptr_gray = r_rptr_gray;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rbin      <= w_rbin_next;
                r_rptr_gray <= bin2gray(w_rbin_next);
            end
        end
    end

    // In-order 2-entry buffer; the head entry always drives m_data
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_buf_head <= '0;
            r_buf_tail <= '0;
            r_bufcnt   <= 2'd0;
        end else begin
            case ({w_pop, r_inflight})
                2'b10: begin
                    r_buf_head <= r_buf_tail;
                    r_bufcnt   <= r_bufcnt - 2'd1;
                end
                2'b01: begin
                    if (r_bufcnt == 2'd0) begin
                        r_buf_head <= mem_rdata;
                    end else begin
                        r_buf_tail <= mem_rdata;
                    end
                    r_bufcnt <= r_bufcnt + 2'd1;
                end
                2'b11: begin
                    if (r_bufcnt == 2'd1) begin
                        r_buf_head <= mem_rdata;
                    end else begin
                        r_buf_head <= r_buf_tail;
                        r_buf_tail <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_valid = (r_bufcnt != 2'd0);
    assign m_data  = r_buf_head;

    // Level counts words still in memory, the outstanding read and the buffer
    assign rlevel  = w_memcnt + c_PW'(r_inflight) + c_PW'(r_bufcnt);
    assign rempty  = (rlevel == '0);
    assign raempty = (rlevel <= c_AE_LVL);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_ctrl
//  Brief    : Directed and randomized bench for fifo_rd_ctrl with a
//             transaction-level reference model and a registered-read memory.
//  Revision : 1.0
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int c_DS = 8;
    localparam int c_AS = 4;

    logic              rclk = 1'b0;
    logic              rrst_n = 1'b1;
    logic [c_AS:0]     wptr_gray = '0;
    logic [c_AS:0]     rptr_gray;
    logic [c_AS-1:0]   mem_addr;
    logic              mem_rinc;
    logic [c_DS-1:0]   mem_rdata = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [c_DS-1:0]   m_data;
    logic [c_AS:0]     rlevel;
    logic              rempty;
    logic              raempty;

    fifo_rd_ctrl #(
        .DATASIZE         (c_DS),
        .ADDRSIZE         (c_AS),
        .ALMOST_EMPTY_LVL (2)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .wptr_gray (wptr_gray),
        .rptr_gray (rptr_gray),
        .mem_addr  (mem_addr),
        .mem_rinc  (mem_rinc),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .rlevel    (rlevel),
        .rempty    (rempty),
        .raempty   (raempty)
    );

    always #5 rclk = ~rclk;

    logic [c_DS-1:0] tb_mem [16];

    always @(posedge rclk) begin
        if (mem_rinc) mem_rdata <= tb_mem[mem_addr];
    end

    int checks = 0;
    int failures = 0;

    // Model: words written so far, words consumed, reads requested, and the
    // write count as seen 1..4 edges ago.
    logic [c_DS-1:0] words[$];
    int wbin = 0, pops = 0, issued = 0;
    int h1 = 0, h2 = 0, h3 = 0, h4 = 0;

    function automatic logic [c_AS:0] bin2gray(input int b);
        logic [c_AS:0] x;
        x = b[c_AS:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [c_AS:0] gray2bin(input logic [c_AS:0] g);
        logic [c_AS:0] b;
        b[c_AS] = g[c_AS];
        for (int i = c_AS - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word();
        logic [c_DS-1:0] d;
        d = c_DS'($urandom);
        tb_mem[wbin % 16] = d;
        words.push_back(d);
        wbin++;
        wptr_gray = bin2gray(wbin);
    endtask

    function automatic logic has_room();
        logic [c_AS:0] d;
        d = wbin[c_AS:0] - gray2bin(rptr_gray);
        return d < 5'd16;
    endfunction

    task automatic cycle();
        logic hs, iss;
        @(negedge rclk);
        chk("rlevel", 32'(rlevel), (h2 - pops) & 31);
        chk("rempty", 32'(rempty), 32'(h2 == pops));
        chk("raempty", 32'(raempty), 32'((h2 - pops) <= 2));
        chk("m_valid", 32'(m_valid), 32'((h4 - pops) != 0));
        chk("rptr_gray", 32'(rptr_gray), 32'(bin2gray(issued)));
        hs  = m_valid && m_ready;
        iss = mem_rinc;
        if (hs) begin
            chk("pop_in_range", 32'(pops < words.size()), 32'd1);
            if (pops < words.size()) chk("m_data", 32'(m_data), 32'(words[pops]));
        end
        if (iss) begin
            chk("mem_addr", 32'(mem_addr), issued % 16);
            chk("read_avail", 32'(issued < h2), 32'd1);
        end
        @(posedge rclk);
        if (hs) pops++;
        if (iss) issued++;
        h4 = h3; h3 = h2; h2 = h1; h1 = wbin;
        #1;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        #2;
        rrst_n    = 1'b0;
        wptr_gray = '0;
        m_ready   = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mem_rinc", 32'(mem_rinc), 32'd0);
        chk("rst_rptr_gray", 32'(rptr_gray), 32'd0);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_raempty", 32'(raempty), 32'd1);
        chk("rst_rlevel", 32'(rlevel), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        wbin = 0; pops = 0; issued = 0;
        h1 = 0; h2 = 0; h3 = 0; h4 = 0;
        words.delete();
        @(posedge rclk);
        @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    task automatic stream(input int n, input int mode, input int budget);
        int written;
        written = 0;
        for (int c = 0; c < budget && pops < n; c++) begin
            if (written < n && has_room() && (mode == 0 || $urandom_range(0, 1) == 1)) begin
                write_word();
                written++;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            cycle();
        end
        chk("stream_pops", pops, n);
        chk("stream_reads", issued, n);
    endtask

    initial begin
        logic [3:0] ae_exp;
        logic seen16, seen32;

        do_reset();

        // Single word
        write_word();
        m_ready = 1'b1;
        cycle();
        cycle();
        chk("single_rinc", 32'(mem_rinc), 32'd1);
        chk("single_addr", 32'(mem_addr), 32'd0);
        cycle();
        cycle();
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'(words[0]));
        chk("single_rptr", 32'(rptr_gray), 32'd1);
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset with reads in flight
        for (int i = 0; i < 3; i++) write_word();
        for (int i = 0; i < 3; i++) cycle();
        do_reset();

        // Backpressure
        for (int i = 0; i < 5; i++) write_word();
        chk("bp_wptr", 32'(wptr_gray), 32'h07);
        for (int i = 0; i < 10; i++) cycle();
        chk("bp_rptr", 32'(rptr_gray), 32'h03);
        chk("bp_rlevel", 32'(rlevel), 32'd5);
        chk("bp_rempty", 32'(rempty), 32'd0);
        chk("bp_no_read", 32'(mem_rinc), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_burst_valid", 32'(m_valid), 32'd1);
            cycle();
        end
        chk("bp_drained", 32'(rempty), 32'd1);
        chk("bp_pops", pops, 5);
        cycle();

        // Pointer wrap over 40 words
        do_reset();
        seen16 = 1'b0;
        seen32 = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 400 && pops < 40; c++) begin
            if (wbin < 40 && has_room()) write_word();
            cycle();
            if (issued == 16 && !seen16) begin
                seen16 = 1'b1;
                chk("wrap_msb_16", 32'(rptr_gray[c_AS]), 32'd1);
            end
            if (issued == 32 && !seen32) begin
                seen32 = 1'b1;
                chk("wrap_msb_32", 32'(rptr_gray[c_AS]), 32'd0);
            end
        end
        chk("wrap_pops", pops, 40);
        chk("wrap_reads", issued, 40);

        // Almost-empty: pop 4 held words one at a time
        do_reset();
        for (int i = 0; i < 4; i++) write_word();
        for (int i = 0; i < 8; i++) cycle();
        chk("ae_level4", 32'(rlevel), 32'd4);
        chk("ae_flag4", 32'(raempty), 32'd0);
        ae_exp = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            m_ready = 1'b1;
            cycle();
            m_ready = 1'b0;
            chk("ae_raempty", 32'(raempty), 32'(ae_exp[i]));
            chk("ae_rempty", 32'(rempty), 32'(i == 3));
            cycle();
            cycle();
        end

        // Ready toggling over 20 words
        do_reset();
        stream(20, 1, 400);
        chk("toggle_empty", 32'(rempty), 32'd1);

        // Random traffic
        do_reset();
        stream(80, 2, 2000);
        for (int i = 0; i < 4; i++) cycle();
        chk("rand_empty", 32'(rempty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
